// File: rtl/cook_pkg.sv
// Shared types and constants for the microwave cook controller.
// Holds the state encoding, the BCD mm:ss layout and the quick-start preset.
package cook_pkg;

  localparam int DIG_W = 4;

  typedef logic [DIG_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COOKING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } cook_state_e;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } mmss_t;

  localparam bcd_t  QS_SEC_TENS      = 4'd3;
  localparam bcd_t  QS_SEC_ONES      = 4'd0;
  localparam mmss_t QUICK_START_TIME = {4'd0, 4'd0, QS_SEC_TENS, QS_SEC_ONES};

endpackage

// File: rtl/mmss_down_counter.sv
// Four-digit BCD mm:ss register: keypad shift-in, clear, preset load and one-step decrement.
// Priority clear > load > shift > decrement; o_one flags that the next decrement reaches 00:00.
module mmss_down_counter
  import cook_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_clr,
  input  logic  i_load,
  input  mmss_t i_load_val,
  input  logic  i_shift,
  input  bcd_t  i_digit,
  input  logic  i_dec,
  output mmss_t o_time,
  output logic  o_zero,
  output logic  o_one
);

  mmss_t r_time;
  mmss_t w_dec;

  // Seconds above 59 are left alone; they simply count down like any other value.
  always_comb begin
    w_dec = r_time;
    if (r_time.sec_ones != '0) begin
      w_dec.sec_ones = r_time.sec_ones - 4'd1;
    end else if (r_time.sec_tens != '0) begin
      w_dec.sec_tens = r_time.sec_tens - 4'd1;
      w_dec.sec_ones = 4'd9;
    end else if (r_time.min_ones != '0) begin
      w_dec.min_ones = r_time.min_ones - 4'd1;
      w_dec.sec_tens = 4'd5;
      w_dec.sec_ones = 4'd9;
    end else if (r_time.min_tens != '0) begin
      w_dec.min_tens = r_time.min_tens - 4'd1;
      w_dec.min_ones = 4'd9;
      w_dec.sec_tens = 4'd5;
      w_dec.sec_ones = 4'd9;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_time <= '0;
    end else if (i_clr) begin
      r_time <= '0;
    end else if (i_load) begin
      r_time <= i_load_val;
    end else if (i_shift) begin
      r_time <= {r_time.min_ones, r_time.sec_tens, r_time.sec_ones, i_digit};
    end else if (i_dec) begin
      r_time <= w_dec;
    end
  end

  assign o_time = r_time;
  assign o_zero = (r_time == '0);
  assign o_one  = (r_time == {12'h000, 4'd1});

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave cook controller: 1 Hz tick sync/edge-detect, keypad entry, start/pause/cancel FSM.
// Optional COOK_QUICK_START_EN: start at 00:00 with the door closed preloads 00:30 and cooks.
module cook_timer_ctrl
  import cook_pkg::*;
#(
  parameter int DONE_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  output logic       magnetron_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state,
  output logic       done
);

  localparam int CNT_W = $clog2(DONE_TICKS + 1);

  logic             r_sync1, r_sync2, r_edge;
  logic             w_tick;
  cook_state_e      r_state, w_next;
  logic             r_mag, r_done;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_clr, w_load, w_shift, w_dec;
  logic             w_zero, w_one;
  mmss_t            w_time;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= tick_in;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
    end
  end

  assign w_tick = r_sync2 & ~r_edge;

  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_dec     = 1'b0;
    w_cnt_nxt = r_cnt;
    case (r_state)
      IDLE: begin
        if (stop_clear) begin
          w_clr = 1'b1;
        end else if (start) begin
          if (door_closed && !w_zero) begin
            w_next = COOKING;
          end
`ifdef COOK_QUICK_START_EN
          else if (door_closed) begin
            w_load = 1'b1;
            w_next = COOKING;
          end
`endif
        end else if (key_valid && (key_digit <= 4'd9)) begin
          w_shift = 1'b1;
        end
      end
      COOKING: begin
        // A tick coinciding with a pause is dropped so the displayed time is what was cooked.
        if (!door_closed || stop_clear) begin
          w_next = PAUSED;
        end else if (w_tick) begin
          w_dec = 1'b1;
          if (w_one) w_next = DONE;
        end
      end
      PAUSED: begin
        if (stop_clear) begin
          w_clr  = 1'b1;
          w_next = IDLE;
        end else if (start && door_closed) begin
          w_next = COOKING;
        end
      end
      DONE: begin
        if (stop_clear || key_valid) begin
          w_clr     = 1'b1;
          w_next    = IDLE;
          w_cnt_nxt = '0;
        end else if (w_tick) begin
          if (r_cnt == CNT_W'(DONE_TICKS - 1)) begin
            w_next    = IDLE;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mag   <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_mag   <= (w_next == COOKING);
      r_done  <= (w_next == DONE);
      r_cnt   <= w_cnt_nxt;
    end
  end

  mmss_down_counter u_mmss (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_load_val (QUICK_START_TIME),
    .i_shift    (w_shift),
    .i_digit    (key_digit),
    .i_dec      (w_dec),
    .o_time     (w_time),
    .o_zero     (w_zero),
    .o_one      (w_one)
  );

  assign magnetron_on = r_mag;
  assign done         = r_done;
  assign state        = r_state;
  assign min_tens     = w_time.min_tens;
  assign min_ones     = w_time.min_ones;
  assign sec_tens     = w_time.sec_tens;
  assign sec_ones     = w_time.sec_ones;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Scoreboard bench for cook_timer_ctrl: expected snapshots queued with each stimulus, popped at negedge.
module tb_cook_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop_clear = 1'b0;
  logic       door_closed = 1'b1;
  logic       magnetron_on;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] state;
  logic       done;

  cook_timer_ctrl #(.DONE_TICKS(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_in      (tick_in),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .start        (start),
    .stop_clear   (stop_clear),
    .door_closed  (door_closed),
    .magnetron_on (magnetron_on),
    .min_tens     (min_tens),
    .min_ones     (min_ones),
    .sec_tens     (sec_tens),
    .sec_ones     (sec_ones),
    .state        (state),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic        mg;
    logic        dn;
    logic [15:0] t;
  } snap_t;

  snap_t exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input string tag, input logic [1:0] st, input logic mg,
                          input logic dn, input logic [15:0] t);
    snap_t s;
    s.st = st; s.mg = mg; s.dn = dn; s.t = t;
    exp_q.push_back(s);
    tag_q.push_back(tag);
  endtask

  task automatic compare_front();
    snap_t e;
    string tg;
    e  = exp_q.pop_front();
    tg = tag_q.pop_front();
    chk({tg, ".state"}, 16'(state), 16'(e.st));
    chk({tg, ".mag"},   16'(magnetron_on), 16'(e.mg));
    chk({tg, ".done"},  16'(done), 16'(e.dn));
    chk({tg, ".time"},  {min_tens, min_ones, sec_tens, sec_ones}, e.t);
  endtask

  task automatic drain();
    @(negedge clk);
    while (exp_q.size() > 0) compare_front();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step();
    key_valid = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic press_clear();
    stop_clear = 1'b1;
    step();
    stop_clear = 1'b0;
  endtask

  // Update lands on the 3rd edge after tick_in is first sampled; low phase lets the edge reg rearm.
  task automatic tick();
    tick_in = 1'b1;
    repeat (3) step();
    tick_in = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    #12;
    exp_push("reset", 2'd0, 1'b0, 1'b0, 16'h0000);
    compare_front();
    step();
    rst_n = 1'b1;
    step();

    // Keypad entry and first cook.
    key(4'd1); exp_push("key1", 2'd0, 1'b0, 1'b0, 16'h0001); drain();
    key(4'd3); key(4'd0);
    exp_push("key130", 2'd0, 1'b0, 1'b0, 16'h0130); drain();
    press_start();
    exp_push("start130", 2'd1, 1'b1, 1'b0, 16'h0130); drain();
    tick(); exp_push("tick1", 2'd1, 1'b1, 1'b0, 16'h0129); drain();
    tick(); tick();
    exp_push("tick3", 2'd1, 1'b1, 1'b0, 16'h0127); drain();
    press_clear();
    exp_push("pause127", 2'd2, 1'b0, 1'b0, 16'h0127); drain();
    press_clear();
    exp_push("clear127", 2'd0, 1'b0, 1'b0, 16'h0000); drain();

    // Minute borrows.
    key(4'd1); key(4'd0); key(4'd0); press_start(); tick();
    exp_push("borrow100", 2'd1, 1'b1, 1'b0, 16'h0059); drain();
    press_clear(); press_clear();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0); press_start(); tick();
    exp_push("borrow1000", 2'd1, 1'b1, 1'b0, 16'h0959); drain();
    press_clear(); press_clear();

    // Countdown to done and timed return to idle.
    key(4'd2); press_start(); tick();
    exp_push("cd01", 2'd1, 1'b1, 1'b0, 16'h0001); drain();
    tick();
    exp_push("done_in", 2'd3, 1'b0, 1'b1, 16'h0000); drain();
    tick(); tick();
    exp_push("done_hold", 2'd3, 1'b0, 1'b1, 16'h0000); drain();
    tick();
    exp_push("done_out", 2'd0, 1'b0, 1'b0, 16'h0000); drain();

    // Key press ends done early without loading the digit.
    key(4'd1); press_start(); tick();
    exp_push("done2", 2'd3, 1'b0, 1'b1, 16'h0000); drain();
    key(4'd5);
    exp_push("done_key", 2'd0, 1'b0, 1'b0, 16'h0000); drain();

    // Door opens on the same cycle as a tick.
    key(4'd4); key(4'd5); press_start();
    tick_in = 1'b1;
    step(); step();
    door_closed = 1'b0;
    step();
    tick_in = 1'b0;
    exp_push("door_tick", 2'd2, 1'b0, 1'b0, 16'h0045); drain();
    repeat (3) step();
    door_closed = 1'b1;
    press_start();
    exp_push("resume", 2'd1, 1'b1, 1'b0, 16'h0045); drain();
    tick();
    exp_push("resume_tick", 2'd1, 1'b1, 1'b0, 16'h0044); drain();

    // Clear beats start in pause; invalid digits ignored.
    press_clear();
    exp_push("pause44", 2'd2, 1'b0, 1'b0, 16'h0044); drain();
    stop_clear = 1'b1; start = 1'b1;
    step();
    stop_clear = 1'b0; start = 1'b0;
    exp_push("clr_over_start", 2'd0, 1'b0, 1'b0, 16'h0000); drain();
    key(4'hA);
    exp_push("keyA", 2'd0, 1'b0, 1'b0, 16'h0000); drain();
    key(4'd7); key(4'hF);
    exp_push("keyF", 2'd0, 1'b0, 1'b0, 16'h0007); drain();
    press_clear();

    // Start with the door open does nothing.
    key(4'd5);
    door_closed = 1'b0;
    press_start();
    exp_push("door_open_start", 2'd0, 1'b0, 1'b0, 16'h0005); drain();
    door_closed = 1'b1;
    press_clear();

    // Start at 00:00.
    press_start();
`ifdef COOK_QUICK_START_EN
    exp_push("zero_start", 2'd1, 1'b1, 1'b0, 16'h0030); drain();
`else
    exp_push("zero_start", 2'd0, 1'b0, 1'b0, 16'h0000); drain();
    key(4'd5); press_start();
    exp_push("cook05", 2'd1, 1'b1, 1'b0, 16'h0005); drain();
`endif

    // Asynchronous reset mid-cook clears everything without waiting for an edge.
    step();
    rst_n = 1'b0;
    #2;
    exp_push("async_rst", 2'd0, 1'b0, 1'b0, 16'h0000);
    compare_front();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
